// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter: op codes and FSM state encoding.
package cmp_pkg;

  localparam logic [2:0] CMP_EQ = 3'd0;
  localparam logic [2:0] CMP_GE = 3'd1;
  localparam logic [2:0] CMP_LE = 3'd2;
  localparam logic [2:0] CMP_GT = 3'd3;
  localparam logic [2:0] CMP_LT = 3'd4;
  localparam logic [2:0] CMP_NE = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned comparator shared by both requesters.
// Ops 6 and 7 produce result 0 and raise illegal.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             result,
  output logic             illegal
);

  // Decode the op code into one unsigned comparison; unknown ops yield 0.
  always_comb begin
    result  = 1'b0;
    illegal = 1'b0;
    case (op)
      CMP_EQ:  result = (a == b);
      CMP_GE:  result = (a >= b);
      CMP_LE:  result = (a <= b);
      CMP_GT:  result = (a >  b);
      CMP_LT:  result = (a <  b);
      CMP_NE:  result = (a != b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one cmp_core between the branch-resolution
// port (0) and the set-on-compare port (1). Accept in IDLE, evaluate in
// EVAL, hold the registered response in RESP until the consumer takes it.
// Optional feature: define CMP_ERR_EN to report ops 6/7 on rsp_err;
// otherwise rsp_err is tied low.
module compare_arbiter
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [2:0]       cap_op;
  logic             cap_id;
  logic             rsp_id_q;
  logic             rsp_result_q;
  logic             cmp_result;
  logic             cmp_illegal;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign req0_ready = ~reset & (state == S_IDLE) & (grant == 1'b0) & req0_valid;
  assign req1_ready = ~reset & (state == S_IDLE) & (grant == 1'b1) & req1_valid;
  assign accept     = req0_ready | req1_ready;

  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a       (cap_a),
    .b       (cap_b),
    .op      (cap_op),
    .result  (cmp_result),
    .illegal (cmp_illegal)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept -> evaluate -> wait for response handshake.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_EVAL;
      S_EVAL:  state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the winning request, register the result, and remember who was served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_a        <= '0;
      cap_b        <= '0;
      cap_op       <= '0;
      cap_id       <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_id <= grant;
            cap_a  <= grant ? req1_a  : req0_a;
            cap_b  <= grant ? req1_b  : req0_b;
            cap_op <= grant ? req1_op : req0_op;
          end
        end
        S_EVAL: begin
          rsp_id_q     <= cap_id;
          rsp_result_q <= cmp_result;
        end
        S_RESP: begin
          if (rsp_ready) last_grant <= rsp_id_q;
        end
        default: ;
      endcase
    end
  end

`ifdef CMP_ERR_EN
  logic rsp_err_q;

  // Illegal-op flag registered alongside the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (state == S_EVAL) begin
      rsp_err_q <= cmp_illegal;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_illegal;
  assign unused_illegal = cmp_illegal;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: reset values, accept/response timing,
// round-robin alternation, unsigned compare, response stall, illegal op,
// and reset during evaluation. Inputs change and outputs are sampled on
// the falling edge.
module tb_compare_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_result;
  logic        rsp_err;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;

`ifdef CMP_ERR_EN
  localparam logic ILLEGAL_ERR = 1'b1;
`else
  localparam logic ILLEGAL_ERR = 1'b0;
`endif

  compare_arbiter #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op);
    if (port == 0) begin
      req0_valid = valid; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = valid; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
  endtask

  task automatic checkIdleReady(input string tag, input logic r0, input logic r1);
    checkOutput({tag, "_r0"}, req0_ready, r0);
    checkOutput({tag, "_r1"}, req1_ready, r1);
  endtask

  // Called at the negedge after the accept edge: checks EVAL, then RESP contents.
  task automatic checkServe(input string tag, input logic id, input logic res, input logic err);
    checkOutput({tag, "_eval_busy"}, busy, 1'b1);
    checkOutput({tag, "_eval_vld"}, rsp_valid, 1'b0);
    checkOutput({tag, "_eval_rdy"}, req0_ready | req1_ready, 1'b0);
    tick();
    checkOutput({tag, "_vld"}, rsp_valid, 1'b1);
    checkOutput({tag, "_id"}, rsp_id, id);
    checkOutput({tag, "_res"}, rsp_result, res);
    checkOutput({tag, "_err"}, rsp_err, err);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();

    // Reset values, with a request pending to prove ready is held low.
    applyStimulus(0, 1'b1, 32'd5, 32'd5, 3'd0);
    checkIdleReady("rst", 1'b0, 1'b0);
    checkOutput("rst_vld", rsp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_id", rsp_id, 1'b0);
    checkOutput("rst_res", rsp_result, 1'b0);
    checkOutput("rst_err", rsp_err, 1'b0);

    // Basic equality request on port 0.
    reset = 1'b0;
    #1;
    checkIdleReady("eq_acc", 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0);
    checkServe("eq", 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("eq_done_vld", rsp_valid, 1'b0);
    checkOutput("eq_done_busy", busy, 1'b0);

    // Tie from reset: port 0 first, then alternation with refreshed payloads.
    doReset();
    applyStimulus(0, 1'b1, 32'd1, 32'd2, 3'd4);
    applyStimulus(1, 1'b1, 32'd1, 32'd2, 3'd3);
    checkIdleReady("rr1", 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 32'd7, 32'd7, 3'd0);
    checkServe("rr1", 1'b0, 1'b1, 1'b0);
    tick();
    checkIdleReady("rr2", 1'b0, 1'b1);
    tick();
    applyStimulus(1, 1'b1, 32'hFFFF_FFFF, 32'd0, 3'd3);
    checkServe("rr2", 1'b1, 1'b0, 1'b0);
    tick();
    checkIdleReady("rr3", 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0);
    checkServe("rr3", 1'b0, 1'b1, 1'b0);
    tick();
    checkIdleReady("rr4", 1'b0, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
    checkServe("unsigned_gt", 1'b1, 1'b1, 1'b0);
    tick();

    // Response stall: rsp_ready low for 5 cycles while port 1 waits.
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 32'd3, 32'd9, 3'd2);
    checkIdleReady("st_acc", 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0);
    applyStimulus(1, 1'b1, 32'd4, 32'd4, 3'd5);
    checkServe("st", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("st_hold_vld", rsp_valid, 1'b1);
      checkOutput("st_hold_id", rsp_id, 1'b0);
      checkOutput("st_hold_res", rsp_result, 1'b1);
      checkOutput("st_hold_r1", req1_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("st_hs_r1", req1_ready, 1'b0);
    tick();
    checkIdleReady("st_next", 1'b0, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
    checkServe("ne", 1'b1, 1'b0, 1'b0);
    tick();

    // Illegal op 6 on port 1.
    applyStimulus(1, 1'b1, 32'd1, 32'd1, 3'd6);
    checkIdleReady("ill_acc", 1'b0, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
    checkServe("ill", 1'b1, 1'b0, ILLEGAL_ERR);
    tick();

    // A legal response after the illegal one clears the error flag.
    applyStimulus(1, 1'b1, 32'd9, 32'd3, 3'd1);
    checkIdleReady("ge_acc", 1'b0, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
    checkServe("ge", 1'b1, 1'b1, 1'b0);
    tick();

    // Reset asserted during EVAL drops the request.
    applyStimulus(0, 1'b1, 32'd2, 32'd2, 3'd0);
    checkIdleReady("mr_acc", 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0);
    checkOutput("mr_eval_busy", busy, 1'b1);
    applyStimulus(1, 1'b1, 32'd1, 32'd1, 3'd0);
    reset = 1'b1;
    #1;
    checkOutput("mr_busy", busy, 1'b0);
    checkOutput("mr_vld", rsp_valid, 1'b0);
    checkOutput("mr_id", rsp_id, 1'b0);
    checkOutput("mr_res", rsp_result, 1'b0);
    checkOutput("mr_err", rsp_err, 1'b0);
    checkIdleReady("mr_rdy", 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mr_norsp", rsp_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
